// File: rtl/ha_serial_seq.sv
// Bit-serial adder controller that time-shares one external half-adder cell.
// Each operand bit uses two passes: a[i]+b[i], then partial sum + carry-in.
module ha_serial_seq #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_s,
    input  logic             ha_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPh1,
        StPh2,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              s1_q, s1_d;
    logic              c1_q, c1_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  a_sh, b_sh;

    // Shift-based bit select keeps WIDTH=1 builds free of zero-width index issues.
    assign a_sh = a_q >> idx_q;
    assign b_sh = b_q >> idx_q;

    // Kept separate from next-state logic so the external half-adder path is not a loop.
    always_comb begin
        ha_a = 1'b0;
        ha_b = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StPh1: begin
                ha_a = a_sh[0];
                ha_b = b_sh[0];
                busy = 1'b1;
            end
            StPh2: begin
                ha_a = s1_q;
                ha_b = carry_q;
                busy = 1'b1;
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StPh1;
                end
            end
            StPh1: begin
                s1_d    = ha_s;
                c1_d    = ha_c;
                state_d = StPh2;
            end
            StPh2: begin
                // sum was cleared at accept, so OR-ing in each bit is sufficient
                sum_d   = sum_q | (WIDTH'(ha_s) << idx_q);
                carry_d = c1_q | ha_c;
                if (idx_q == IdxLast) begin
                    cout_d  = c1_q | ha_c;
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StPh1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
